y_mux4to1: RTL and testbench
============================

# y_mux4to1

Parameterised-width 4-to-1 multiplexer for the datapath lab blocks. It selects one of four SIZE-bit words with a 2-bit select and presents the result two ways:

- combinationally on `z`, for zero-latency use;
- through a pipeline register on `z_q`, for clocked consumers.

It is the next level above the 2-to-1 mux in the mux hierarchy and is reused by the ALU and register-file read ports.

## Interface
Parameters:
- `SIZE`, default 32: data width of every input and output word.

Ports:
- `clk` input 1: single clock; `z_q` and `sel_q` update on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low; clears all registers immediately on assertion.
- `z` output SIZE: combinational selected word.
- `a0` input SIZE: data input, selected when c = 0.
- `a1` input SIZE: data input, selected when c = 1.
- `a2` input SIZE: data input, selected when c = 2.
- `a3` input SIZE: data input, selected when c = 3.
- `c` input 2: select. A 1-bit driver connected here zero-extends, so 0 selects a0 and 1 selects a1.
- `z_q` output SIZE: registered copy of `z`.
- `sel_q` output 2: registered copy of `c`, aligned with `z_q`.

## Operation
- Selection rule: z = a0 when c = 0, a1 when c = 1, a2 when c = 2, a3 when c = 3.
- Selection is bitwise and independent per bit. Bit i of z is bit i of the selected input for every i in 0..SIZE-1.
- Mux tree, three 2-to-1 stages:
  - lo = c[0] ? a1 : a0
  - hi = c[0] ? a3 : a2
  - z = c[1] ? hi : lo
- X/Z on `c`: z may be X. No explicit handling; no latch may be inferred.
- Registered path, on each rising `clk` with rst_n high: z_q <= z and sel_q <= c.
- Reset: while rst_n = 0, z_q = 0 and sel_q = 0 regardless of the clock.
- No enable, no handshake; the register captures on every edge.

## Timing
- `z`: purely combinational, no clock dependency. It must settle within one propagation delay of any change on a0..a3 or c (bench samples 1 time unit after stimulus).
- `z_q`, `sel_q`: latency exactly 1 clock cycle from the inputs present at the rising edge.
- Reset asserted asynchronously mid-operation: z_q and sel_q go to 0 immediately, without waiting for a clock edge; z is unaffected.
- Reset deasserted: the first capture happens at the next rising edge after rst_n goes high.
- Select and data changing in the same cycle: the edge captures the combination present at the edge; there is no glitch memory.

## Structure
- Sub-module `y_mux2to1 #(SIZE)` with ports (z, a, b, c), where z = c ? b : a.
  - Built from SIZE instances of a 1-bit gate-level mux (NOT/AND/OR), generated with a generate loop.
  - y_mux4to1 instantiates it three times.
- Shared package `y_mux_pkg`:
  - `SEL_W` = 2;
  - enum `sel_t` with values SEL_A0 = 0, SEL_A1, SEL_A2, SEL_A3;
  - default `SIZE` localparam of 32.
- The pipeline register lives in y_mux4to1, in one always block sensitive to posedge clk and negedge rst_n.

## Test plan
- Select sweep, SIZE = 32: a0 = 0x11111111, a1 = 0x22222222, a2 = 0x33333333, a3 = 0x44444444; c = 0,1,2,3 -> z = 0x11111111, 0x22222222, 0x33333333, 0x44444444 respectively, each checked 1 time unit after stimulus.
- Random: 10 iterations of $random on a0..a3 and c -> z matches the selected input on all 32 bits, with c restricted to 0/1 and also over the full range 0..3.
- Bit independence: a0 = 0xAAAAAAAA, a1 = 0x55555555, c = 1 -> z = 0x55555555; then c = 0 -> z = 0xAAAAAAAA.
- Pipeline: rst_n = 0 -> z_q = 0 and sel_q = 0; release, drive c = 2 with a2 = 0xDEADBEEF -> z_q = 0xDEADBEEF and sel_q = 2 after exactly one rising edge, and z_q still 0 before that edge.
- Async reset mid-stream: z_q = 0xDEADBEEF, assert rst_n = 0 between edges -> z_q = 0 immediately, z unchanged.
- Width parameter: SIZE = 8, a3 = 0xF0, c = 3 -> z = 0xF0 and, one edge later, z_q = 0xF0.

Source files
------------

// File: rtl/y_mux_pkg.sv
// Shared definitions for the y_mux family: select width, select encoding and default data width.
package y_mux_pkg;

  localparam int SEL_W    = 2;
  localparam int DEF_SIZE = 32;

  typedef enum logic [SEL_W-1:0] {
    SEL_A0 = 2'd0,
    SEL_A1 = 2'd1,
    SEL_A2 = 2'd2,
    SEL_A3 = 2'd3
  } sel_t;

endpackage

// File: rtl/y_mux2to1.sv
// SIZE-bit 2-to-1 mux: z = c ? b : a, one NOT/AND/OR gate mux per bit.
module y_mux2to1
  import y_mux_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
) (
  output logic [SIZE-1:0] z,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            c
);

  wire            c_n;
  wire [SIZE-1:0] z_bits;

  // The inverted select is shared by every bit slice.
  not u_inv (c_n, c);

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    wire term_a;
    wire term_b;
    and u_and_a (term_a, a[i], c_n);
    and u_and_b (term_b, b[i], c);
    or  u_or    (z_bits[i], term_a, term_b);
  end

  assign z = z_bits;

endmodule

// File: rtl/y_mux4to1.sv
// SIZE-bit 4-to-1 mux with a combinational output and a registered copy of result and select.
module y_mux4to1
  import y_mux_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [SIZE-1:0]  z,
  input  logic [SIZE-1:0]  a0,
  input  logic [SIZE-1:0]  a1,
  input  logic [SIZE-1:0]  a2,
  input  logic [SIZE-1:0]  a3,
  input  logic [SEL_W-1:0] c,
  output logic [SIZE-1:0]  z_q,
  output logic [SEL_W-1:0] sel_q
);

  logic [SIZE-1:0] lo;
  logic [SIZE-1:0] hi;

  // c[0] picks within each pair, c[1] picks between the pairs.
  y_mux2to1 #(.SIZE(SIZE)) u_lo (.z(lo), .a(a0), .b(a1), .c(c[0]));
  y_mux2to1 #(.SIZE(SIZE)) u_hi (.z(hi), .a(a2), .b(a3), .c(c[0]));
  y_mux2to1 #(.SIZE(SIZE)) u_out (.z(z), .a(lo), .b(hi), .c(c[1]));

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q   <= '0;
      sel_q <= '0;
    end else begin
      z_q   <= z;
      sel_q <= c;
    end
  end

endmodule

// File: tb/tb_y_mux4to1.sv
// Randomised and directed bench for y_mux4to1 at SIZE=32 and SIZE=8 against an array-indexed model.
module tb_y_mux4to1;
  import y_mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a32 [4];
  logic [1:0]  c32;
  logic [31:0] z32, z_q32;
  logic [1:0]  sel_q32;
  logic [7:0]  a8 [4];
  logic [1:0]  c8;
  logic [7:0]  z8, z_q8;
  logic [1:0]  sel_q8;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model of the registered outputs: selected word and select seen at the last edge out of reset.
  logic [31:0] m_zq32  = '0;
  logic [1:0]  m_sel32 = '0;
  logic [7:0]  m_zq8   = '0;
  logic [1:0]  m_sel8  = '0;

  always #5 clk = ~clk;

  y_mux4to1 #(.SIZE(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .z(z32),
    .a0(a32[0]), .a1(a32[1]), .a2(a32[2]), .a3(a32[3]),
    .c(c32), .z_q(z_q32), .sel_q(sel_q32)
  );

  y_mux4to1 #(.SIZE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .z(z8),
    .a0(a8[0]), .a1(a8[1]), .a2(a8[2]), .a3(a8[3]),
    .c(c8), .z_q(z_q8), .sel_q(sel_q8)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      m_zq32  <= a32[c32];
      m_sel32 <= c32;
      m_zq8   <= a8[c8];
      m_sel8  <= c8;
    end
  end

  always @(negedge rst_n) begin
    m_zq32  <= '0;
    m_sel32 <= '0;
    m_zq8   <= '0;
    m_sel8  <= '0;
  end

  // Continuous comparison away from the active edge.
  always @(negedge clk) begin
    if ($time > 1) begin
      check("z32_model",     z32,            a32[c32]);
      check("zq32_model",    z_q32,          m_zq32);
      check("selq32_model",  32'(sel_q32),   32'(m_sel32));
      check("z8_model",      32'(z8),        32'(a8[c8]));
      check("zq8_model",     32'(z_q8),      32'(m_zq8));
      check("selq8_model",   32'(sel_q8),    32'(m_sel8));
    end
  end

  // Inputs change 2 time units after a rising edge, clear of both clock edges.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a32[i] = '0;
      a8[i]  = '0;
    end
    c32 = '0;
    c8  = '0;
    #1 rst_n = 1'b0;

    // Reset state
    step();
    #1;
    check("reset_zq", z_q32, 32'h0);
    check("reset_selq", 32'(sel_q32), 32'h0);
    check("reset_zq8", 32'(z_q8), 32'h0);

    // Pipeline latency from reset release
    step();
    rst_n  = 1'b1;
    a32[2] = 32'hDEADBEEF;
    c32    = SEL_A2;
    #1;
    check("pipe_z_comb", z32, 32'hDEADBEEF);
    check("pipe_zq_before_edge", z_q32, 32'h0);
    @(posedge clk);
    #1;
    check("pipe_zq_after_edge", z_q32, 32'hDEADBEEF);
    check("pipe_selq_after_edge", 32'(sel_q32), 32'h2);

    // Asynchronous reset between edges
    #1;
    rst_n = 1'b0;
    #1;
    check("async_zq_cleared", z_q32, 32'h0);
    check("async_selq_cleared", 32'(sel_q32), 32'h0);
    check("async_z_unchanged", z32, 32'hDEADBEEF);
    step();
    rst_n = 1'b1;

    // Select sweep
    a32[0] = 32'h11111111;
    a32[1] = 32'h22222222;
    a32[2] = 32'h33333333;
    a32[3] = 32'h44444444;
    for (int s = 0; s < 4; s++) begin
      step();
      c32 = 2'(s);
      #1;
      check($sformatf("sweep_c%0d", s), z32, {8{4'(s + 1)}});
    end

    // Bit independence
    step();
    a32[0] = 32'hAAAAAAAA;
    a32[1] = 32'h55555555;
    c32    = 2'd1;
    #1;
    check("bits_c1", z32, 32'h55555555);
    step();
    c32 = 2'd0;
    #1;
    check("bits_c0", z32, 32'hAAAAAAAA);

    // Narrow instance
    step();
    a8[3] = 8'hF0;
    c8    = 2'd3;
    #1;
    check("w8_z", 32'(z8), 32'h000000F0);
    @(posedge clk);
    #1;
    check("w8_zq", 32'(z_q8), 32'h000000F0);

    // Random, select restricted to 0/1 then full range
    for (int r = 0; r < 20; r++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        a32[i] = $urandom;
        a8[i]  = 8'($urandom);
      end
      c32 = (r < 10) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      c8  = (r < 10) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      #1;
      check("rand_z", z32, a32[c32]);
    end

    // Longer random run with occasional reset pulses
    for (int r = 0; r < 300; r++) begin
      step();
      rst_n = ($urandom_range(0, 39) != 0);
      for (int i = 0; i < 4; i++) begin
        a32[i] = $urandom;
        a8[i]  = 8'($urandom);
      end
      c32 = 2'($urandom);
      c8  = 2'($urandom);
    end
    step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
